line_scanout: RTL and testbench

Ping-pong line buffer that sits between the sprite drawers and the VGA output stage. The draw side accepts `pixel_col`/`pixel_data`/`wren` writes into the bank being composed for the next scanline. The scan side reads the other bank by column with a fixed two-cycle latency and substitutes the background colour for empty entries. Every entry it reads is cleared, so each bank arrives at the draw side empty after its line has been displayed.

---
 rtl/line_pkg.sv | 16 +
 rtl/line_scanout_ram.sv | 25 ++
 rtl/line_scanout.sv | 156 +++++++++++++++
 tb/tb_line_scanout.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_pkg.sv
// Shared types and constants for the scanline ping-pong buffer.
package line_pkg;

    localparam int          LINE_WIDTH = 640;
    localparam logic [15:0] PIX_EMPTY  = 16'h8000;

    typedef logic [15:0] pixel_t;
    typedef logic [9:0]  col_t;
    typedef enum logic {S_INIT, S_RUN} scan_state_t;

    // Bit 15 marks an entry that holds no drawn pixel.
    function automatic logic is_empty(input pixel_t pix);
        return pix[15];
    endfunction

endpackage

// File: rtl/line_scanout_ram.sv
// One scanline bank: single write port, synchronous registered-address read.
module line_ram
    import line_pkg::*;
#(
    parameter int DEPTH = LINE_WIDTH
) (
    input  logic        clk,
    input  logic        we,
    input  logic [9:0]  waddr,
    input  logic [15:0] wdata,
    input  logic [9:0]  raddr,
    output logic [15:0] rdata
);

    pixel_t mem [DEPTH];

    // Read returns the pre-write contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_scanout.sv
// Ping-pong line buffer: draw side fills one bank while the scan side reads
// and clears the other, substituting BG_COLOR for empty entries.
module line_scanout
    import line_pkg::*;
#(
    parameter int          WIDTH    = LINE_WIDTH,
    parameter logic [15:0] BG_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_col,
    input  logic [15:0] pixel_data,
    input  logic        wren,
    input  logic        line_start,
    input  logic        rd_en,
    input  logic [9:0]  rd_col,
    output logic [15:0] pixel_out,
    output logic        pixel_valid,
    output logic        ready
);

    localparam col_t WIDTH_C = col_t'(WIDTH);
    localparam col_t LAST_C  = col_t'(WIDTH - 1);

    scan_state_t state;
    col_t        init_col;
    logic        wr_bank;

    logic   s1_valid, s1_bank, s1_bg;
    col_t   s1_col;
    logic   s2_valid, s2_bank, s2_bg, s2_fwd;
    col_t   s2_col;

    logic   [1:0] we;
    col_t   waddr [2];
    pixel_t wdata [2];
    pixel_t rdata [2];

    logic   draw_hit, clear_hit, rd_bg;
    pixel_t entry, out_pix;

    assign draw_hit  = wren && (pixel_col < WIDTH_C);
    assign clear_hit = s2_valid && !s2_bg;
    assign rd_bg     = (state == S_INIT) || (rd_col >= WIDTH_C);

    // Sweep control, bank toggle and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_INIT;
            init_col <= 10'd0;
            wr_bank  <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_col <= init_col + 10'd1;
                    if (init_col == LAST_C) begin
                        state <= S_RUN;
                        ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (line_start) begin
                        wr_bank <= ~wr_bank;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Per-bank write port: sweep, then draw, then clear-on-read. A clear only
    // meets a draw in the same bank after a mid-flight swap; the newer draw wins.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b]    = 1'b0;
            waddr[b] = 10'd0;
            wdata[b] = PIX_EMPTY;
            if (state == S_INIT) begin
                we[b]    = 1'b1;
                waddr[b] = init_col;
            end else if (draw_hit && (wr_bank == b[0])) begin
                we[b]    = 1'b1;
                waddr[b] = pixel_col;
                wdata[b] = pixel_data;
            end else if (clear_hit && (s2_bank == b[0])) begin
                we[b]    = 1'b1;
                waddr[b] = s2_col;
            end else begin
                we[b]    = 1'b0;
            end
        end
    end

    line_ram #(.DEPTH(WIDTH)) u_bank0 (
        .clk   (clk),
        .we    (we[0]),
        .waddr (waddr[0]),
        .wdata (wdata[0]),
        .raddr (s1_col),
        .rdata (rdata[0])
    );

    line_ram #(.DEPTH(WIDTH)) u_bank1 (
        .clk   (clk),
        .we    (we[1]),
        .waddr (waddr[1]),
        .wdata (wdata[1]),
        .raddr (s1_col),
        .rdata (rdata[1])
    );

    // Output selection: reads issued during the sweep or out of range, and
    // reads shadowed by a not-yet-written clear, all show background.
    always_comb begin
        entry = s2_bank ? rdata[1] : rdata[0];
        if (s2_bg || s2_fwd || is_empty(entry)) begin
            out_pix = BG_COLOR;
        end else begin
            out_pix = entry;
        end
    end

    // Two-stage read pipeline; the bank bit rides along so a swap cannot
    // redirect a pending clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_col      <= 10'd0;
            s1_bank     <= 1'b0;
            s1_bg       <= 1'b0;
            s2_valid    <= 1'b0;
            s2_col      <= 10'd0;
            s2_bank     <= 1'b0;
            s2_bg       <= 1'b0;
            s2_fwd      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_out   <= 16'h0000;
        end else begin
            s1_valid    <= rd_en;
            s1_col      <= rd_col;
            s1_bank     <= ~wr_bank;
            s1_bg       <= rd_bg;
            s2_valid    <= s1_valid;
            s2_col      <= s1_col;
            s2_bank     <= s1_bank;
            s2_bg       <= s1_bg;
            s2_fwd      <= clear_hit && (s2_col == s1_col) && (s2_bank == s1_bank);
            pixel_valid <= s2_valid;
            if (s2_valid) begin
                pixel_out <= out_pix;
            end
        end
    end

endmodule

// File: tb/tb_line_scanout.sv
// Directed self-checking bench for line_scanout.
module tb_line_scanout;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixel_col = 10'd0;
    logic [15:0] pixel_data = 16'h0000;
    logic        wren = 1'b0;
    logic        line_start = 1'b0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_col = 10'd0;
    logic [15:0] pixel_out;
    logic        pixel_valid;
    logic        ready;

    int checks = 0;
    int errors = 0;

    logic [15:0] got_pix [640];
    logic        got_val [640];

    line_scanout dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_col   (pixel_col),
        .pixel_data  (pixel_data),
        .wren        (wren),
        .line_start  (line_start),
        .rd_en       (rd_en),
        .rd_col      (rd_col),
        .pixel_out   (pixel_out),
        .pixel_valid (pixel_valid),
        .ready       (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic draw(input logic [9:0] col, input logic [15:0] data);
        wren = 1'b1; pixel_col = col; pixel_data = data;
        tick();
        wren = 1'b0;
    endtask

    task automatic swap();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Single read; ve is pixel_valid one cycle after the sampling edge.
    task automatic read1(input logic [9:0] col, output logic [15:0] p,
                         output logic ve, output logic v);
        rd_en = 1'b1; rd_col = col;
        tick();
        rd_en = 1'b0;
        tick();
        ve = pixel_valid;
        tick();
        p = pixel_out;
        v = pixel_valid;
    endtask

    // Back-to-back reads of columns 0..639, capturing each result two edges later.
    task automatic do_scan();
        for (int j = 0; j < 642; j++) begin
            rd_en  = (j < 640);
            rd_col = 10'(j);
            tick();
            if (j >= 2) begin
                got_pix[j-2] = pixel_out;
                got_val[j-2] = pixel_valid;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", pixel_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b expected 0", ready); end
        checks++; if (pixel_out !== 16'h0000) begin errors++; $display("FAIL reset_pixel got %h expected 0000", pixel_out); end
        reset = 1'b0;
        for (int k = 1; k <= 640; k++) begin
            tick();
            checks++;
            if (ready !== (k == 640)) begin errors++; $display("FAIL init_ready cycle %0d got %b expected %b", k, ready, (k == 640)); end
        end
        do_scan();
        for (int c = 0; c < 640; c++) begin
            checks++;
            if (got_val[c] !== 1'b1 || got_pix[c] !== 16'h0000) begin
                errors++; $display("FAIL first_scan col %0d got %h/%b expected 0000/1", c, got_pix[c], got_val[c]);
            end
        end
        tick();
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b expected 0", pixel_valid); end
    endtask

    task automatic test_draw_swap();
        logic [15:0] exp;
        draw(10'd5, 16'h1234);
        draw(10'd639, 16'h7FFF);
        swap();
        do_scan();
        for (int c = 0; c < 640; c++) begin
            if (c == 5) exp = 16'h1234;
            else if (c == 639) exp = 16'h7FFF;
            else exp = 16'h0000;
            checks++;
            if (got_val[c] !== 1'b1 || got_pix[c] !== exp) begin
                errors++; $display("FAIL draw_scan col %0d got %h/%b expected %h/1", c, got_pix[c], got_val[c], exp);
            end
        end
        swap();
        swap();
        do_scan();
        for (int c = 0; c < 640; c++) begin
            checks++;
            if (got_val[c] !== 1'b1 || got_pix[c] !== 16'h0000) begin
                errors++; $display("FAIL cleared_scan col %0d got %h/%b expected 0000/1", c, got_pix[c], got_val[c]);
            end
        end
    endtask

    task automatic test_overdraw();
        logic [15:0] p;
        logic ve, v;
        draw(10'd10, 16'h0001);
        draw(10'd10, 16'h0002);
        draw(10'd640, 16'h0055);
        swap();
        read1(10'd10, p, ve, v);
        checks++; if (ve !== 1'b0) begin errors++; $display("FAIL latency_early got %b expected 0", ve); end
        checks++; if (v !== 1'b1 || p !== 16'h0002) begin errors++; $display("FAIL overdraw got %h/%b expected 0002/1", p, v); end
        read1(10'd640, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0000) begin errors++; $display("FAIL out_of_range got %h/%b expected 0000/1", p, v); end
        read1(10'd10, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0000) begin errors++; $display("FAIL reread_cleared got %h/%b expected 0000/1", p, v); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] p;
        logic ve, v;
        wren = 1'b1; pixel_col = 10'd3; pixel_data = 16'h0ABC; line_start = 1'b1;
        tick();
        wren = 1'b0; line_start = 1'b0;
        read1(10'd3, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0ABC) begin errors++; $display("FAIL wren_with_swap got %h/%b expected 0abc/1", p, v); end
        swap();
        read1(10'd3, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0000) begin errors++; $display("FAIL post_toggle_bank got %h/%b expected 0000/1", p, v); end
        draw(10'd20, 16'h1111);
        swap();
        rd_en = 1'b1; rd_col = 10'd20;
        tick();
        rd_en = 1'b0; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h1111) begin errors++; $display("FAIL swap_midflight got %h/%b expected 1111/1", pixel_out, pixel_valid); end
        swap();
        read1(10'd20, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0000) begin errors++; $display("FAIL pending_clear_bank got %h/%b expected 0000/1", p, v); end
        swap();
        draw(10'd21, 16'h2222);
        swap();
        rd_en = 1'b1; rd_col = 10'd21; line_start = 1'b1;
        tick();
        rd_en = 1'b0; line_start = 1'b0;
        tick(); tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h2222) begin errors++; $display("FAIL rd_with_swap got %h/%b expected 2222/1", pixel_out, pixel_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p;
        logic ve, v;
        draw(10'd7, 16'h0777);
        draw(10'd8, 16'h0888);
        swap();
        rd_en = 1'b1; rd_col = 10'd7;
        tick();
        tick();
        rd_col = 10'd8;
        tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h0777) begin errors++; $display("FAIL fwd_first got %h/%b expected 0777/1", pixel_out, pixel_valid); end
        rd_en = 1'b0;
        tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h0000) begin errors++; $display("FAIL fwd_second got %h/%b expected 0000/1", pixel_out, pixel_valid); end
        tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h0888) begin errors++; $display("FAIL fwd_neighbour got %h/%b expected 0888/1", pixel_out, pixel_valid); end
        read1(10'd7, p, ve, v);
        checks++; if (v !== 1'b1 || p !== 16'h0000) begin errors++; $display("FAIL fwd_later got %h/%b expected 0000/1", p, v); end
    endtask

    task automatic test_reset_mid();
        draw(10'd100, 16'h0100);
        swap();
        draw(10'd101, 16'h0101);
        rd_en = 1'b1; rd_col = 10'd100;
        tick();
        rd_col = 10'd101;
        tick();
        rd_col = 10'd102;
        tick();
        checks++; if (pixel_valid !== 1'b1 || pixel_out !== 16'h0100) begin errors++; $display("FAIL pre_reset_read got %h/%b expected 0100/1", pixel_out, pixel_valid); end
        reset = 1'b1; rd_en = 1'b0;
        #1;
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b expected 0", pixel_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b expected 0", ready); end
        tick(); tick();
        reset = 1'b0;
        for (int k = 1; k <= 640; k++) begin
            tick();
            if (k >= 639) begin
                checks++;
                if (ready !== (k == 640)) begin errors++; $display("FAIL reinit_ready cycle %0d got %b expected %b", k, ready, (k == 640)); end
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            do_scan();
            for (int c = 0; c < 640; c++) begin
                checks++;
                if (got_val[c] !== 1'b1 || got_pix[c] !== 16'h0000) begin
                    errors++; $display("FAIL resweep pass %0d col %0d got %h/%b expected 0000/1", pass, c, got_pix[c], got_val[c]);
                end
            end
            swap();
        end
    endtask

    initial begin
        test_reset();
        test_draw_swap();
        test_overdraw();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
